cook_timer_ctrl: RTL
====================

COOK_TIMER_CTRL -- requirements
Module: cook_timer_ctrl

Interface
REQ-001 SHALL have parameter SEC_RELOAD, default 5, giving the seconds-tens value loaded on borrow.
REQ-002 SHALL have input clk, 1 bit: clock; all state updates on its rising edge.
REQ-003 SHALL have input rstn, 1 bit: reset, asynchronous, active-low.
REQ-004 SHALL have input tick_1hz, 1 bit: one-clk-wide pulse, once per second.
REQ-005 SHALL have input key_valid, 1 bit: one-clk-wide pulse qualifying key_digit.
REQ-006 SHALL have input key_digit, 4 bits: keypad digit, valid range 0-9.
REQ-007 SHALL have input start, 1 bit: one-clk-wide start/resume request.
REQ-008 SHALL have input stop_clear, 1 bit: one-clk-wide pause/clear request.
REQ-009 SHALL have input door_closed, 1 bit: level; 1 = door closed.
REQ-010 SHALL have outputs min_tens, min_units, sec_tens, sec_units, 4 bits each: BCD time digits (MM:SS).
REQ-011 SHALL have output magnetron_on, 1 bit: registered; 1 only in COOK.
REQ-012 SHALL have output done, 1 bit: registered; 1 only in DONE.
REQ-013 SHALL have output state, 2 bits: IDLE=00, COOK=01, PAUSE=10, DONE=11.

Function
REQ-014 SHALL implement a 4-state FSM (IDLE, COOK, PAUSE, DONE), one transition per clk at most.
REQ-015 In IDLE, key_valid with key_digit <= 9 SHALL shift digits left: min_tens<-min_units, min_units<-sec_tens, sec_tens<-sec_units, sec_units<-key_digit; the old min_tens is discarded.
REQ-016 key_valid with key_digit > 9, or key_valid in any state other than IDLE, SHALL be ignored (except as in REQ-025).
REQ-017 Entered sec_tens values 6-9 SHALL be accepted unchanged (e.g. 00:90 = 90 s).
REQ-018 IDLE->COOK SHALL occur on start when door_closed=1 and time != 00:00; otherwise start SHALL be ignored.
REQ-019 In COOK, each tick_1hz SHALL decrement the time by one second with a BCD borrow chain:
  - sec_units 0->9 with borrow, otherwise -1;
  - sec_tens 0->SEC_RELOAD with borrow, otherwise -1;
  - min_units 0->9 with borrow, otherwise -1;
  - min_tens -1.
REQ-020 The tick that makes the time 00:00 SHALL move the FSM to DONE on the same edge; magnetron_on SHALL fall and done SHALL rise on that edge.
REQ-021 COOK->PAUSE SHALL occur when door_closed=0 or stop_clear=1; any tick in that cycle SHALL be ignored and the digits held.
REQ-022 PAUSE->COOK SHALL occur on start with door_closed=1; digits SHALL be unchanged in PAUSE.
REQ-023 PAUSE->IDLE SHALL occur on stop_clear and SHALL clear all digits to 0.
REQ-024 Priority within one cycle SHALL be: door_closed=0 > stop_clear > start > tick_1hz > key_valid.
REQ-025 DONE->IDLE SHALL occur on stop_clear, key_valid (digit not shifted in), or door_closed=0; digits remain 00:00.
REQ-026 In IDLE, stop_clear SHALL clear all digits to 0.
REQ-027 Digit outputs SHALL always be in range 0-9; no illegal BCD state SHALL be reachable.

Reset
REQ-028 rstn=0 SHALL immediately force state=IDLE, all digits=0, magnetron_on=0, done=0, independent of clk.
REQ-029 Reset asserted mid-COOK SHALL abort cooking with no further tick effect.
REQ-030 After rstn rises, the first action SHALL be taken on the next rising clk edge.

Verification
REQ-031 Keys 1,3,0 then start, door closed -> display 01:30, state=01, magnetron_on=1; next tick -> 01:29.
REQ-032 Time 01:00, COOK, one tick -> 00:59; time 00:01, one tick -> 00:00, state=11, done=1, magnetron_on=0 on the same edge.
REQ-033 COOK at 00:45, door_closed=0 together with a tick -> state=10, display 00:45; door closes, start -> COOK, next tick -> 00:44.
REQ-034 start with time 00:00, or with door_closed=0 -> state stays 00; key_digit=12 with key_valid -> digits unchanged.
REQ-035 Same cycle start=1 and stop_clear=1 in PAUSE -> IDLE with digits 00:00; stop_clear in DONE -> IDLE.
REQ-036 rstn pulsed low between clk edges during COOK at 02:10 -> outputs 00:00, state=00, magnetron_on=0 before the next edge.

Source files
------------

// File: rtl/cook_timer_ctrl.sv
// ============================================================================
// Module   : cook_timer_ctrl
// Brief    : Microwave cook timer: keypad entry of MM:SS, BCD countdown, door
//            interlock and IDLE/COOK/PAUSE/DONE control.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module cook_timer_ctrl #(
    parameter int unsigned SEC_RELOAD = 5
) (
    input  logic       clk,
    input  logic       rstn,
    input  logic       tick_1hz,
    input  logic       key_valid,
    input  logic [3:0] key_digit,
    input  logic       start,
    input  logic       stop_clear,
    input  logic       door_closed,
    output logic [3:0] min_tens,
    output logic [3:0] min_units,
    output logic [3:0] sec_tens,
    output logic [3:0] sec_units,
    output logic       magnetron_on,
    output logic       done,
    output logic [1:0] state
);

    localparam logic [3:0] C_SEC_RELOAD = 4'(SEC_RELOAD);
    localparam logic [3:0] C_NINE       = 4'd9;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        COOK  = 2'b01,
        PAUSE = 2'b10,
        DONE  = 2'b11
    } state_t;

    state_t     state_q, state_d;
    logic [3:0] min_tens_q, min_tens_d;
    logic [3:0] min_units_q, min_units_d;
    logic [3:0] sec_tens_q, sec_tens_d;
    logic [3:0] sec_units_q, sec_units_d;
    logic       magnetron_on_q, magnetron_on_d;
    logic       done_q, done_d;

    logic [3:0] mt_dec, mu_dec, st_dec, su_dec;
    logic       time_zero, dec_zero;

    // One-second BCD decrement; a seconds-tens borrow reloads to SEC_RELOAD.
    always_comb begin
        su_dec = (sec_units_q == 4'd0) ? C_NINE : sec_units_q - 4'd1;
        st_dec = sec_tens_q;
        mu_dec = min_units_q;
        mt_dec = min_tens_q;
        if (sec_units_q == 4'd0) begin
            st_dec = (sec_tens_q == 4'd0) ? C_SEC_RELOAD : sec_tens_q - 4'd1;
            if (sec_tens_q == 4'd0) begin
                mu_dec = (min_units_q == 4'd0) ? C_NINE : min_units_q - 4'd1;
                if (min_units_q == 4'd0) begin
                    mt_dec = min_tens_q - 4'd1;
                end
            end
        end
    end

    assign time_zero = ({min_tens_q, min_units_q, sec_tens_q, sec_units_q} == 16'h0000);
    assign dec_zero  = ({mt_dec, mu_dec, st_dec, su_dec} == 16'h0000);

    always_comb begin
        state_d     = state_q;
        min_tens_d  = min_tens_q;
        min_units_d = min_units_q;
        sec_tens_d  = sec_tens_q;
        sec_units_d = sec_units_q;
        case (state_q)
            IDLE: begin
                if (stop_clear) begin
                    {min_tens_d, min_units_d, sec_tens_d, sec_units_d} = 16'h0000;
                end else if (start && door_closed && !time_zero) begin
                    state_d = COOK;
                end else if (key_valid && (key_digit <= C_NINE)) begin
                    min_tens_d  = min_units_q;
                    min_units_d = sec_tens_q;
                    sec_tens_d  = sec_units_q;
                    sec_units_d = key_digit;
                end
            end
            COOK: begin
                if (!door_closed || stop_clear) begin
                    state_d = PAUSE;
                end else if (tick_1hz) begin
                    {min_tens_d, min_units_d, sec_tens_d, sec_units_d} =
                        {mt_dec, mu_dec, st_dec, su_dec};
                    if (dec_zero) begin
                        state_d = DONE;
                    end
                end
            end
            PAUSE: begin
                if (stop_clear) begin
                    state_d = IDLE;
                    {min_tens_d, min_units_d, sec_tens_d, sec_units_d} = 16'h0000;
                end else if (start && door_closed) begin
                    state_d = COOK;
                end
            end
            default: begin
                if (stop_clear || key_valid || !door_closed) begin
                    state_d = IDLE;
                end
            end
        endcase
        magnetron_on_d = (state_d == COOK);
        done_d         = (state_d == DONE);
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q        <= IDLE;
            min_tens_q     <= 4'd0;
            min_units_q    <= 4'd0;
            sec_tens_q     <= 4'd0;
            sec_units_q    <= 4'd0;
            magnetron_on_q <= 1'b0;
            done_q         <= 1'b0;
        end else begin
            state_q        <= state_d;
            min_tens_q     <= min_tens_d;
            min_units_q    <= min_units_d;
            sec_tens_q     <= sec_tens_d;
            sec_units_q    <= sec_units_d;
            magnetron_on_q <= magnetron_on_d;
            done_q         <= done_d;
        end
    end

    assign min_tens     = min_tens_q;
    assign min_units    = min_units_q;
    assign sec_tens     = sec_tens_q;
    assign sec_units    = sec_units_q;
    assign magnetron_on = magnetron_on_q;
    assign done         = done_q;
    assign state        = state_q;

endmodule

`default_nettype wire
